// File: rtl/sram_req_ctrl_if.sv
// Request/response channel between a client and the SRAM request front-end.
// The master drives requests and rsp_ready; the slave (the controller) answers.
interface sram_req_ctrl_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 9,
   parameter int ID_WIDTH   = 4
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_wr;
   logic [DATA_WIDTH/8-1:0] req_be;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [ID_WIDTH-1:0]     req_id;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic [ID_WIDTH-1:0]     rsp_id;

   modport master (
      output req_valid, req_wr, req_be, req_addr, req_wdata, req_id, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_id
   );

   modport slave (
      input  req_valid, req_wr, req_be, req_addr, req_wdata, req_id, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_id
   );
endinterface

// File: rtl/sram_req_ctrl.sv
// Front-end for a 1-cycle-latency single-port SRAM: issues requests, captures
// read data and returns it in order through a credit-protected response FIFO.
module sram_req_ctrl #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 9,
   parameter int ID_WIDTH   = 4,
   parameter int RESP_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   sram_req_ctrl_if.slave          bus,
   output logic                    mem_en,
   output logic                    mem_wr,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    busy
);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic [ID_WIDTH-1:0]   id;
   } rsp_t;

   rsp_t             fifo_mem [RESP_DEPTH];
   rsp_t             head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic [SUM_W-1:0] credits_used;
   logic             rd_pending;
   logic [ID_WIDTH-1:0] pend_id;
   logic             fire, push, pop;

   // An in-flight read holds a FIFO slot so its capture can never overflow.
   assign credits_used  = {1'b0, fifo_count} + SUM_W'(rd_pending);
   assign bus.req_ready = credits_used < SUM_W'(RESP_DEPTH);
   assign fire          = bus.req_valid && bus.req_ready;

   assign mem_en    = fire;
   assign mem_wr    = bus.req_wr;
   assign mem_be    = bus.req_wr ? bus.req_be : '1;
   assign mem_addr  = bus.req_addr;
   assign mem_wdata = bus.req_wdata;

   assign push = rd_pending;
   assign pop  = bus.rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending <= 1'b0;
         pend_id    <= '0;
      end else begin
         rd_pending <= fire && !bus.req_wr;
         if (fire && !bus.req_wr) pend_id <= bus.req_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // mem_rdata is only sampled on the cycle after a read was issued.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{rdata: mem_rdata, id: pend_id};
   end

   // Head is gated by valid so the outputs read as zero out of reset.
   assign head          = fifo_mem[rd_ptr];
   assign bus.rsp_valid = fifo_count != '0;
   assign bus.rsp_rdata = bus.rsp_valid ? head.rdata : '0;
   assign bus.rsp_id    = bus.rsp_valid ? head.id    : '0;

   assign busy = rd_pending || (fifo_count != '0);
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard bench: a reference memory predicts each read at issue time and a
// monitor pops/compares whenever a response handshake completes.
module tb_sram_req_ctrl;
   localparam int DW = 128, AW = 9, IW = 4, DEPTH = 4, BW = DW / 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_en, mem_wr, busy;
   logic [BW-1:0] mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          preload, rdy_man, rdy_rnd, rand_rdy;

   logic [DW-1:0] sram    [2**AW];
   logic [DW-1:0] ref_mem [2**AW];
   exp_t          exp_q [$];
   int            n_pass = 0, n_total = 0;
   int            n_acc = 0, n_rsp = 0, n_stall = 0;

   always #5 clk = ~clk;

   sram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

   assign bus.rsp_ready = rand_rdy ? rdy_rnd : rdy_man;

   sram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .RESP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Single-port synchronous SRAM: writes commit at the edge, reads return next cycle.
   always @(posedge clk) begin
      if (preload) begin
         for (int a = 0; a < 2**AW; a++) sram[a] <= (a == 16) ? {BW{8'hA5}} : '0;
      end else if (mem_en) begin
         if (mem_wr) begin
            for (int b = 0; b < BW; b++)
               if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   task automatic monitor();
      logic          hold = 1'b0;
      logic [DW-1:0] h_data = '0;
      logic [IW-1:0] h_id = '0;
      exp_t          e;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_rdata", bus.rsp_rdata, h_data);
            chk("hold_id", bus.rsp_id, h_id);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", bus.rsp_id, '1);
               chk("unexpected_rsp_any", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", bus.rsp_rdata, e.data);
               chk("rsp_id", bus.rsp_id, e.id);
            end
         end
         hold   = bus.rsp_valid && !bus.rsp_ready;
         h_data = bus.rsp_rdata;
         h_id   = bus.rsp_id;
         if (bus.req_valid && !bus.req_ready) n_stall++;
         if (bus.req_valid && bus.req_ready) begin
            n_acc++;
            if (bus.req_wr) begin
               for (int b = 0; b < BW; b++)
                  if (bus.req_be[b]) ref_mem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
            end else begin
               exp_q.push_back('{data: ref_mem[bus.req_addr], id: bus.req_id});
            end
         end
      end
   endtask

   task automatic rdy_gen();
      forever begin
         @(posedge clk);
         #1 rdy_rnd = ($urandom_range(0, 9) < 3);
      end
   endtask

   task automatic drive(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [BW-1:0] be, input logic [IW-1:0] id);
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      bus.req_be    = be;
      bus.req_id    = id;
   endtask

   // Returns one ns after the accepting edge with req_valid dropped.
   task automatic wait_accept();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            return;
         end
      end
      chk("accept_timeout", 1'b0, 1'b1);
      bus.req_valid = 1'b0;
   endtask

   task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [BW-1:0] be, input logic [IW-1:0] id);
      drive(wr, addr, data, be, id);
      wait_accept();
   endtask

   task automatic drain(string name);
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < 600) begin
         @(posedge clk);
         #1 k++;
      end
      chk(name, (exp_q.size() == 0) && !busy, 1'b1);
   endtask

   initial begin
      int acc0, rsp0, stall0;
      rst = 1'b1; preload = 1'b1; rdy_man = 1'b0; rdy_rnd = 1'b0; rand_rdy = 1'b0;
      bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_be = '0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.req_id = '0;
      for (int a = 0; a < 2**AW; a++) ref_mem[a] = (a == 16) ? {BW{8'hA5}} : '0;
      fork
         monitor();
         rdy_gen();
      join_none

      repeat (2) @(posedge clk);
      #1;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", bus.rsp_rdata, '0);
      chk("rst_id", bus.rsp_id, '0);
      chk("rst_req_ready", bus.req_ready, 1);
      preload = 1'b0;
      rst = 1'b0;

      // Basic read of the preloaded word, cycle-exact latency.
      rdy_man = 1'b1;
      @(posedge clk); #1;
      drive(1'b0, 9'h010, '0, '0, 4'd3);
      @(negedge clk);
      chk("t1_mem_en_T", mem_en, 1);
      chk("t1_mem_wr", mem_wr, 0);
      chk("t1_mem_be", mem_be, {BW{1'b1}});
      chk("t1_mem_addr", mem_addr, 9'h010);
      @(posedge clk); #1 bus.req_valid = 1'b0;
      @(negedge clk);
      chk("t1_mem_en_T1", mem_en, 0);
      chk("t1_valid_T1", bus.rsp_valid, 0);
      chk("t1_busy_T1", busy, 1);
      @(negedge clk);
      chk("t1_valid_T2", bus.rsp_valid, 1);
      chk("t1_rdata_T2", bus.rsp_rdata, {BW{8'hA5}});
      chk("t1_id_T2", bus.rsp_id, 4'd3);
      @(posedge clk); #1;

      // Partial write then read-after-write on the next cycle.
      drive(1'b1, 9'h020, 128'h00112233445566778899AABBCCDDEEFF, 16'h00FF, 4'd0);
      @(negedge clk);
      chk("t2_mem_be_wr", mem_be, 16'h00FF);
      chk("t2_mem_wr", mem_wr, 1);
      @(posedge clk); #1;
      send(1'b0, 9'h020, '0, '0, 4'd7);
      @(negedge clk);
      chk("t2_valid_T1", bus.rsp_valid, 0);
      @(negedge clk);
      chk("t2_valid_T2", bus.rsp_valid, 1);
      chk("t2_rdata", bus.rsp_rdata, 128'h0000000000000000_8899AABBCCDDEEFF);
      @(posedge clk); #1;
      drain("t2_drain");

      // Back-pressure: only DEPTH reads fit while the consumer stalls.
      rdy_man = 1'b0;
      acc0 = n_acc; rsp0 = n_rsp;
      for (int i = 0; i < 4; i++) send(1'b0, (i % 2) ? 9'h020 : 9'h010, '0, '0, IW'(i));
      drive(1'b0, 9'h010, '0, '0, 4'd4);
      repeat (4) begin
         @(negedge clk);
         chk("t3_ready_low", bus.req_ready, 0);
      end
      chk("t3_accepted", n_acc - acc0, 4);
      @(posedge clk); #1 rdy_man = 1'b1;
      wait_accept();
      send(1'b0, 9'h020, '0, '0, 4'd5);
      drain("t3_drain");
      chk("t3_rsp_count", n_rsp - rsp0, 6);

      // Streaming alternating write/read with no stalls.
      stall0 = n_stall; rsp0 = n_rsp;
      for (int i = 0; i < 32; i++) begin
         send(1'b1, AW'(i), {$urandom, $urandom, $urandom, $urandom}, '1, 4'd0);
         send(1'b0, AW'(i), '0, '0, IW'(i));
      end
      drain("t4_drain");
      chk("t4_no_stall", n_stall - stall0, 0);
      chk("t4_rsp_count", n_rsp - rsp0, 32);

      // Reset with two buffered responses and one read in flight.
      rdy_man = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b0, 9'h010, '0, '0, IW'(8 + i));
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("t5_valid_rst", bus.rsp_valid, 0);
      chk("t5_busy_rst", busy, 0);
      chk("t5_ready_rst", bus.req_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      rdy_man = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t5_no_stale", bus.rsp_valid, 0);
      end
      @(posedge clk); #1;
      send(1'b0, 9'h010, '0, '0, 4'd12);
      drain("t5_recover");

      // Random traffic against a 30% duty consumer.
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
              {$urandom, $urandom, $urandom, $urandom}, BW'($urandom), IW'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain("t6_drain");
      rand_rdy = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request front-end that sits directly upstream of the single-port synchronous SRAM macro model in the sram_group.
- Accepts read/write requests over a valid/ready channel and drives the SRAM's en/wr/be/addr/data_in pins.
- Tracks the SRAM's 1-cycle read latency.
- Returns read data, tagged with the request ID, through a buffered valid/ready response channel. The buffer guarantees no read data is ever lost under back-pressure.

Parameters:
- DATA_WIDTH, 128, SRAM word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 9, SRAM address width in bits.
- ID_WIDTH, 4, width of the request/response tag.
- RESP_DEPTH, 4, response FIFO depth in entries; must be at least 2, power of two.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_wr  in  1  1 = write, 0 = read.
- req_be  in  DATA_WIDTH/8  byte enables for writes; ignored for reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_id  in  ID_WIDTH  tag returned with read data.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_id  out  ID_WIDTH  tag of the read.
- mem_en  out  1  to SRAM en.
- mem_wr  out  1  to SRAM wr.
- mem_be  out  DATA_WIDTH/8  to SRAM be.
- mem_addr  out  ADDR_WIDTH  to SRAM addr.
- mem_wdata  out  DATA_WIDTH  to SRAM data_in.
- mem_rdata  in  DATA_WIDTH  from SRAM data_out; valid exactly one cycle after a read is issued.
- busy  out  1  a read is pending, or the response FIFO is non-empty.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Port names are clk and rst.
- Reset state: FIFO pointers and count = 0, rd_pending = 0, rsp_valid = 0, busy = 0.
  - rsp_rdata and rsp_id reset to 0.
  - Reset asserted mid-operation discards any pending read and all buffered responses; none are ever presented.
- fire = req_valid && req_ready.
- req_ready = (fifo_count + rd_pending) < RESP_DEPTH.
  - Registered-state only: no combinational path from req_* or rsp_ready.
  - Applies to reads and writes alike.
- SRAM drive (combinational from the request port):
  - mem_en = fire; mem_wr = req_wr.
  - mem_be = req_be when req_wr = 1, else all-ones.
  - mem_addr = req_addr; mem_wdata = req_wdata.
- No SRAM access happens without fire.
- Read issue: on fire with req_wr = 0, set rd_pending <= 1 and pend_id <= req_id. Otherwise rd_pending <= 0.
- Read capture: in the cycle rd_pending = 1, push {mem_rdata, pend_id} into the FIFO.
  - The credit rule guarantees space, so the push is never dropped.
  - mem_rdata is sampled only while rd_pending = 1; its unreset value is never exposed.
- Response channel:
  - rsp_valid = fifo_count != 0; rsp_rdata and rsp_id come from the FIFO head.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle leave the count unchanged, and ordering is preserved.
  - Head data holds stable while rsp_valid && !rsp_ready.
- Latency: read accepted in cycle T; SRAM data available in T+1; FIFO written at end of T+1; rsp_valid first high in T+2.
- Ordering and hazards:
  - Responses return strictly in request order.
  - A write accepted at T followed by a read to the same address at T+1 returns the new data. The SRAM commits writes at the clock edge, so no forwarding is needed.
- Throughput: with rsp_ready held high and RESP_DEPTH >= 4, one request is accepted per cycle indefinitely.
- Writes produce no response.
- A write with be = 0 is still issued and leaves memory unchanged.
- FIFO wrap-around: pointers are log2(RESP_DEPTH) bits and wrap naturally; full = count == RESP_DEPTH.
- busy = rd_pending || fifo_count != 0.

Test Plan:
- Reset → SRAM model preloaded at addr 0x010 with 0xA5 per byte. Read addr 0x010, id 3, rsp_ready = 1 → rsp_valid in cycle T+2 with rdata = 0xA5A5…A5, id = 3; mem_en high only in cycle T.
- Write addr 0x020, data 0x00112233…FF, be = 0x00FF; next cycle read 0x020 → rdata has the new bytes 0–7 and zeros in bytes 8–15, and returns in T+2.
- Back-pressure: rsp_ready = 0, issue 6 back-to-back reads (ids 0–5) → exactly 4 accepted (req_ready drops once count + pending = 4). Release rsp_ready → ids 0,1,2,3 returned in order, then the remaining reads are accepted.
- Streaming: 64 alternating writes/reads to addresses 0–31 with rsp_ready = 1 → req_ready never low, each read data matches the prior write, and 32 responses arrive in order.
- Reset pulse in the cycle after a read is issued, with 2 responses buffered → rsp_valid = 0 and busy = 0 immediately; no stale response appears after reset is released.
- Randomised rsp_ready at 30% duty with random reads/writes → scoreboard matches a reference memory; rsp_rdata and rsp_id never change while rsp_valid && !rsp_ready.
